// File: rtl/sys_bus_pkg.sv
// Shared system-bus types: bus guard state encoding, default error data and
// the response record also used by the interconnect's test models.
package sys_bus_pkg;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        WAIT = 1'b1
    } guard_state_t;

    localparam logic [31:0] SYS_BUS_ERR_RDATA = 32'hDEAD_C0DE;

    typedef struct packed {
        logic [31:0] rdata;
        logic        err;
    } sys_bus_rsp_t;

    function automatic sys_bus_rsp_t sys_bus_err_rsp(input logic [31:0] rdata);
        sys_bus_rsp_t rsp;
        rsp.rdata = rdata;
        rsp.err   = 1'b1;
        return rsp;
    endfunction

endpackage

// File: rtl/sys_bus_if.sv
// System-bus signal bundle. Handshake: a strobe (wen/ren) is a one-cycle
// request qualified by addr/wdata; ack is a one-cycle response qualified by rdata/err.
interface sys_bus_if;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        wen;
    logic        ren;
    logic [31:0] rdata;
    logic        err;
    logic        ack;

    modport m (output addr, wdata, wen, ren, input rdata, err, ack);
    modport s (input addr, wdata, wen, ren, output rdata, err, ack);
endinterface

// File: rtl/sys_bus_sat_cnt.sv
// Saturating event counter with synchronous clear; an increment in the
// same cycle as clear wins and leaves the count at one.
module sys_bus_sat_cnt #(
    parameter int W = 16
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         inc_i,
    input  logic         clr_i,
    output logic [W-1:0] cnt_o
);

    logic [W-1:0] r_cnt;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_cnt <= '0;
        end else if (inc_i) begin
            if (clr_i)
                r_cnt <= W'(1);
            else if (r_cnt != {W{1'b1}})
                r_cnt <= r_cnt + W'(1);
        end else if (clr_i) begin
            r_cnt <= '0;
        end
    end

    assign cnt_o = r_cnt;

endmodule

// File: rtl/sys_bus_guard.sv
// Single-outstanding system-bus stage: forwards one request at a time and
// terminates it with an error response if the slave does not ack in time.
module sys_bus_guard
    import sys_bus_pkg::*;
#(
    parameter int          TW        = 16,
    parameter int          TMO       = 255,
    parameter logic [31:0] ERR_RDATA = SYS_BUS_ERR_RDATA
) (
    input  logic          clk_i,
    input  logic          rst_i,
    sys_bus_if.s          bus_m,
    sys_bus_if.m          bus_s,
    input  logic          clr_i,
    output logic          busy_o,
    output logic [TW-1:0] tmo_cnt_o,
    output logic          ovr_o
);

    localparam logic [TW-1:0] TMO_LAST = TW'(TMO - 1);

    guard_state_t  r_state;
    logic [31:0]   r_addr;
    logic [31:0]   r_wdata;
    logic          r_s_wen;
    logic          r_s_ren;
    logic          r_m_ack;
    sys_bus_rsp_t  r_rsp;
    logic [TW-1:0] r_wait_cnt;
    logic          r_ovr;

    logic w_req;
    logic w_strobe;
    logic w_tmo;
    logic w_viol;

    assign w_req    = bus_m.wen | bus_m.ren;
    assign w_strobe = r_s_wen | r_s_ren;
    // The strobe cycle itself is not counted, so the slave gets TMO full cycles after it.
    assign w_tmo    = (r_state == WAIT) && !bus_s.ack && !w_strobe && (r_wait_cnt == TMO_LAST);
    assign w_viol   = ((r_state == IDLE) && bus_m.wen && bus_m.ren) ||
                      ((r_state == WAIT) && w_req);

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state    <= IDLE;
            r_addr     <= '0;
            r_wdata    <= '0;
            r_s_wen    <= 1'b0;
            r_s_ren    <= 1'b0;
            r_m_ack    <= 1'b0;
            r_rsp      <= '0;
            r_wait_cnt <= '0;
        end else begin
            r_s_wen <= 1'b0;
            r_s_ren <= 1'b0;
            r_m_ack <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (w_req) begin
                        r_addr     <= bus_m.addr;
                        r_wdata    <= bus_m.wdata;
                        r_s_wen    <= bus_m.wen;
                        r_s_ren    <= bus_m.ren & ~bus_m.wen;
                        r_wait_cnt <= '0;
                        r_state    <= WAIT;
                    end
                end
                WAIT: begin
                    if (bus_s.ack) begin
                        r_m_ack     <= 1'b1;
                        r_rsp.rdata <= bus_s.rdata;
                        r_rsp.err   <= bus_s.err;
                        r_state     <= IDLE;
                    end else if (w_tmo) begin
                        r_m_ack <= 1'b1;
                        r_rsp   <= sys_bus_err_rsp(ERR_RDATA);
                        r_state <= IDLE;
                    end else if (!w_strobe) begin
                        r_wait_cnt <= r_wait_cnt + TW'(1);
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i)
            r_ovr <= 1'b0;
        else if (w_viol)
            r_ovr <= 1'b1;
        else if (clr_i)
            r_ovr <= 1'b0;
    end

    sys_bus_sat_cnt #(.W(TW)) u_tmo_cnt (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .inc_i (w_tmo),
        .clr_i (clr_i),
        .cnt_o (tmo_cnt_o)
    );

    assign bus_s.addr  = r_addr;
    assign bus_s.wdata = r_wdata;
    assign bus_s.wen   = r_s_wen;
    assign bus_s.ren   = r_s_ren;
    assign bus_m.ack   = r_m_ack;
    assign bus_m.rdata = r_rsp.rdata;
    assign bus_m.err   = r_rsp.err;
    assign busy_o      = (r_state == WAIT);
    assign ovr_o       = r_ovr;

endmodule

// File: tb/tb_sys_bus_guard.sv
// Directed bench for sys_bus_guard: a TMO=255 instance for protocol and
// timeout behaviour, and a TW=4/TMO=3 instance for counter saturation.
module tb_sys_bus_guard;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic clr = 1'b0;
    logic clr4 = 1'b0;

    always #5 clk = ~clk;

    sys_bus_if m_if ();
    sys_bus_if s_if ();
    sys_bus_if m4_if ();
    sys_bus_if s4_if ();

    logic        busy, ovr, busy4, ovr4;
    logic [15:0] tmo_cnt;
    logic [3:0]  tmo_cnt4;

    sys_bus_guard #(.TW(16), .TMO(255), .ERR_RDATA(32'hDEAD_C0DE)) dut (
        .clk_i(clk), .rst_i(rst), .bus_m(m_if), .bus_s(s_if), .clr_i(clr),
        .busy_o(busy), .tmo_cnt_o(tmo_cnt), .ovr_o(ovr)
    );

    sys_bus_guard #(.TW(4), .TMO(3), .ERR_RDATA(32'hDEAD_C0DE)) dut4 (
        .clk_i(clk), .rst_i(rst), .bus_m(m4_if), .bus_s(s4_if), .clr_i(clr4),
        .busy_o(busy4), .tmo_cnt_o(tmo_cnt4), .ovr_o(ovr4)
    );

    int n_checks = 0;
    int n_errors = 0;
    int ack_cnt = 0;
    int strobe_cnt = 0;
    logic [32:0] exp_q[$];

    always @(negedge clk) begin
        if (m_if.ack === 1'b1) ack_cnt++;
        if ((s_if.wen === 1'b1) || (s_if.ren === 1'b1)) strobe_cnt++;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_rsp(input string tag);
        logic [32:0] e;
        chk({tag, "_q"}, exp_q.size(), 1);
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk({tag, "_ack"}, m_if.ack, 1);
            chk({tag, "_err"}, m_if.err, e[32]);
            chk({tag, "_rdata"}, m_if.rdata, e[31:0]);
        end
    endtask

    task automatic wait_ack(input int limit, input bit use4, output int n);
        n = 0;
        while (n < limit) begin
            tick();
            n++;
            if ((use4 ? m4_if.ack : m_if.ack) === 1'b1) return;
        end
        n = limit + 1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        int base;
        m_if.addr = '0;  m_if.wdata = '0;  m_if.wen = 1'b0;  m_if.ren = 1'b0;
        s_if.rdata = '0; s_if.err = 1'b0;  s_if.ack = 1'b0;
        m4_if.addr = '0; m4_if.wdata = '0; m4_if.wen = 1'b0; m4_if.ren = 1'b0;
        s4_if.rdata = '0; s4_if.err = 1'b0; s4_if.ack = 1'b0;

        repeat (2) @(posedge clk);
        #1;
        chk("rst_busy", busy, 0);
        chk("rst_s_wen", s_if.wen, 0);
        chk("rst_s_addr", s_if.addr, 0);
        chk("rst_m_ack", m_if.ack, 0);
        chk("rst_tmo_cnt", tmo_cnt, 0);
        chk("rst_ovr", ovr, 0);
        rst = 1'b0;
        tick();

        // Read, slave acks one cycle after the strobe
        m_if.addr = 32'h0000_1000; m_if.ren = 1'b1;
        tick();
        chk("rd_s_ren", s_if.ren, 1);
        chk("rd_s_wen", s_if.wen, 0);
        chk("rd_s_addr", s_if.addr, 32'h0000_1000);
        chk("rd_busy", busy, 1);
        m_if.ren = 1'b0;
        tick();
        chk("rd_s_ren_pulse", s_if.ren, 0);
        chk("rd_no_early_ack", m_if.ack, 0);
        s_if.ack = 1'b1; s_if.rdata = 32'h1234_5678; s_if.err = 1'b0;
        exp_q.push_back({1'b0, 32'h1234_5678});
        tick();
        check_rsp("rd");
        chk("rd_busy_done", busy, 0);
        s_if.ack = 1'b0;
        tick();
        chk("rd_ack_pulse", m_if.ack, 0);
        chk("rd_strobes", strobe_cnt, 1);

        // Write timeout: ack 256 cycles after the strobe cycle
        m_if.addr = 32'h0030_0010; m_if.wdata = 32'hCAFE_0001; m_if.wen = 1'b1;
        tick();
        chk("wr_s_wen", s_if.wen, 1);
        chk("wr_s_ren", s_if.ren, 0);
        chk("wr_s_addr", s_if.addr, 32'h0030_0010);
        chk("wr_s_wdata", s_if.wdata, 32'hCAFE_0001);
        m_if.wen = 1'b0;
        wait_ack(300, 1'b0, n);
        chk("tmo_latency", n, 256);
        exp_q.push_back({1'b1, 32'hDEAD_C0DE});
        check_rsp("tmo");
        chk("tmo_cnt1", tmo_cnt, 1);
        tick();
        chk("tmo_busy", busy, 0);

        // Slave ack on the last allowed cycle wins over the timeout
        m_if.addr = 32'h0000_2000; m_if.ren = 1'b1;
        tick();
        m_if.ren = 1'b0;
        repeat (255) tick();
        chk("edge_no_ack_yet", m_if.ack, 0);
        chk("edge_busy", busy, 1);
        s_if.ack = 1'b1; s_if.rdata = 32'hA5A5_0001; s_if.err = 1'b0;
        exp_q.push_back({1'b0, 32'hA5A5_0001});
        tick();
        check_rsp("edge");
        chk("edge_tmo_cnt", tmo_cnt, 1);
        s_if.ack = 1'b0;
        tick();

        // Late ack two cycles after a timeout is discarded
        m_if.addr = 32'h0000_3000; m_if.ren = 1'b1;
        tick();
        m_if.ren = 1'b0;
        wait_ack(300, 1'b0, n);
        chk("late_latency", n, 256);
        exp_q.push_back({1'b1, 32'hDEAD_C0DE});
        check_rsp("late_tmo");
        tick();
        base = ack_cnt;
        s_if.ack = 1'b1; s_if.rdata = 32'h1111_1111;
        tick();
        s_if.ack = 1'b0;
        repeat (2) tick();
        chk("late_no_ack", ack_cnt, base);
        chk("late_tmo_cnt", tmo_cnt, 2);
        chk("late_busy", busy, 0);

        // Strobe during WAIT: not forwarded, sets ovr
        chk("ovr_clean", ovr, 0);
        base = strobe_cnt;
        m_if.addr = 32'h0000_4000; m_if.ren = 1'b1;
        tick();
        m_if.ren = 1'b0;
        repeat (2) tick();
        m_if.addr = 32'h0000_5000; m_if.ren = 1'b1;
        tick();
        m_if.ren = 1'b0;
        chk("ovr_set", ovr, 1);
        chk("ovr_no_fwd", s_if.ren, 0);
        s_if.ack = 1'b1; s_if.rdata = 32'h0BAD_F00D; s_if.err = 1'b1;
        exp_q.push_back({1'b1, 32'h0BAD_F00D});
        tick();
        check_rsp("ovr_rsp");
        s_if.ack = 1'b0; s_if.err = 1'b0;
        chk("ovr_strobes", strobe_cnt, base + 1);
        clr = 1'b1;
        tick();
        clr = 1'b0;
        chk("ovr_clr", ovr, 0);
        chk("clr_tmo_cnt", tmo_cnt, 0);

        // wen+ren together with clr: write wins, ovr set despite clr; same-cycle ack
        m_if.addr = 32'h0000_6000; m_if.wen = 1'b1; m_if.ren = 1'b1; clr = 1'b1;
        tick();
        m_if.wen = 1'b0; m_if.ren = 1'b0; clr = 1'b0;
        chk("both_s_wen", s_if.wen, 1);
        chk("both_s_ren", s_if.ren, 0);
        chk("both_ovr_wins", ovr, 1);
        s_if.ack = 1'b1; s_if.rdata = 32'h0000_0088;
        exp_q.push_back({1'b0, 32'h0000_0088});
        tick();
        check_rsp("min_rt");
        s_if.ack = 1'b0;
        // New request in the ack cycle is accepted
        m_if.addr = 32'h0000_9000; m_if.ren = 1'b1;
        tick();
        m_if.ren = 1'b0;
        chk("b2b_s_ren", s_if.ren, 1);
        chk("b2b_s_addr", s_if.addr, 32'h0000_9000);
        s_if.ack = 1'b1; s_if.rdata = 32'h0000_0099;
        exp_q.push_back({1'b0, 32'h0000_0099});
        tick();
        check_rsp("b2b");
        s_if.ack = 1'b0;
        clr = 1'b1;
        tick();
        clr = 1'b0;
        chk("b2b_ovr_clr", ovr, 0);

        // Narrow counter saturates at 15
        for (int i = 0; i < 20; i++) begin
            m4_if.ren = 1'b1;
            tick();
            m4_if.ren = 1'b0;
            wait_ack(10, 1'b1, n);
            chk("sat_latency", n, 4);
            if (i == 13) chk("sat_cnt14", tmo_cnt4, 14);
        end
        chk("sat_cnt15", tmo_cnt4, 15);
        chk("sat_err", m4_if.err, 1);
        chk("sat_rdata", m4_if.rdata, 32'hDEAD_C0DE);
        tick();
        // Timeout coinciding with clear leaves the count at one
        m4_if.ren = 1'b1;
        tick();
        m4_if.ren = 1'b0;
        repeat (3) tick();
        clr4 = 1'b1;
        tick();
        clr4 = 1'b0;
        chk("clr_tmo_ack", m4_if.ack, 1);
        chk("clr_tmo_cnt", tmo_cnt4, 1);

        // Reset mid-WAIT abandons the transaction
        m_if.addr = 32'h0000_A000; m_if.ren = 1'b1;
        tick();
        m_if.ren = 1'b0;
        tick();
        base = ack_cnt;
        rst = 1'b1;
        #1;
        chk("mrst_busy", busy, 0);
        chk("mrst_s_addr", s_if.addr, 0);
        chk("mrst_m_rdata", m_if.rdata, 0);
        chk("mrst_m_ack", m_if.ack, 0);
        chk("mrst_tmo4", tmo_cnt4, 0);
        tick();
        rst = 1'b0;
        tick();
        s_if.ack = 1'b1; s_if.rdata = 32'hEEEE_EEEE;
        tick();
        s_if.ack = 1'b0;
        tick();
        chk("mrst_no_ack", ack_cnt, base);
        chk("mrst_idle", busy, 0);
        m_if.addr = 32'h0000_B000; m_if.ren = 1'b1;
        tick();
        m_if.ren = 1'b0;
        chk("post_s_ren", s_if.ren, 1);
        s_if.ack = 1'b1; s_if.rdata = 32'hB0B0_B0B0;
        exp_q.push_back({1'b0, 32'hB0B0_B0B0});
        tick();
        check_rsp("post");
        s_if.ack = 1'b0;
        tick();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/sys_bus_guard.md
Name: sys_bus_guard

Overview:
- Single-outstanding request stage between the system-bus master (the AXI-to-sys_bus bridge) and the system bus interconnect.
- Registers request strobes toward the interconnect and registers responses back to the master.
- Terminates any transaction the addressed slave fails to acknowledge within a programmable cycle budget: returns an error acknowledge, so the master never hangs on an unmapped or dead slave.
- Exposes timeout and protocol-violation status for debug.

Parameters:
- TW, 16, width of the timeout counter and of the timeout-event counter.
- TMO, 255, cycles waited for slave ack before forced termination (1 to 2**TW-1).
- ERR_RDATA, 32'hDEAD_C0DE, rdata returned on a timed-out read.

Ports:
- clk_i  input  1  system clock
- rst_i  input  1  asynchronous, active-high reset
- bus_m  sys_bus_if.s  -  from master (addr 32, wdata 32, wen, ren in; rdata 32, err, ack out)
- bus_s  sys_bus_if.m  -  to interconnect (addr 32, wdata 32, wen, ren out; rdata 32, err, ack in)
- clr_i  input  1  synchronous clear of tmo_cnt_o and ovr_o
- busy_o  output  1  transaction outstanding
- tmo_cnt_o  output  TW  saturating count of timed-out transactions
- ovr_o  output  1  sticky: request received while busy

Behaviour:
- Reset: all outputs 0 (bus_s.addr/wdata/wen/ren, bus_m.rdata/err/ack, busy_o, tmo_cnt_o, ovr_o). State IDLE, wait counter 0. Asynchronous assertion; deassertion is synchronous to clk_i by design.
- States: IDLE, WAIT.
- IDLE, bus_m.wen or bus_m.ren high in cycle N:
  - Latch addr and wdata.
  - Drive bus_s.addr/wdata from the latch and pulse bus_s.wen or bus_s.ren for exactly one cycle in N+1.
  - Go to WAIT with busy_o=1 from N+1.
- Simultaneous wen and ren: write wins, only bus_s.wen pulses, ovr_o is set.
- WAIT, bus_s.ack=1 in cycle M (M ≥ N+1; a same-cycle ack in N+1 is legal):
  - In M+1, bus_m.ack=1 for one cycle, with bus_m.rdata=bus_s.rdata and bus_m.err=bus_s.err captured at M.
  - Go to IDLE; busy_o=0 from M+1.
- Wait counter: cleared on entry to WAIT, increments each WAIT cycle without ack.
- Timeout, wait counter == TMO-1 with no ack:
  - Next cycle: bus_m.ack=1, err=1, rdata=ERR_RDATA (writes also return ERR_RDATA).
  - tmo_cnt_o increments, saturating at 2**TW-1.
  - Go to IDLE.
  - Total budget: ack accepted up to TMO cycles after the bus_s strobe cycle.
- Ack and timeout in the same cycle: ack wins, normal response, no count.
- Late slave ack arriving in IDLE: discarded, no bus_m.ack, no status change.
- New bus_m strobe while in WAIT: not forwarded, not acknowledged, ovr_o set.
- A new request in the same cycle as the bus_m.ack pulse is legal (state is IDLE by then) and is accepted.
- bus_m.rdata/err hold their last value between acks; they are only meaningful when bus_m.ack=1.
- clr_i: clears tmo_cnt_o and ovr_o next cycle. A timeout or violation in the same cycle as clr_i takes precedence: result is tmo_cnt_o=1 / ovr_o=1.
- Reset during WAIT: transaction abandoned, no ack issued. A slave ack arriving after reset release is discarded.
- Throughput: at most one transaction in flight. Minimum round trip is 2 cycles from bus_m strobe to bus_m.ack.

Decomposition:
- sys_bus_pkg holds:
  - enum logic [0:0] {IDLE, WAIT} guard_state_t.
  - Default ERR_RDATA constant SYS_BUS_ERR_RDATA.
  - Response struct {rdata, err}, shared with the interconnect's test models.
- Sub-module sys_bus_sat_cnt (width param, inc, clr, sat output), instanced for the timeout-event counter.
- Wait counter stays inline because it clears on state entry.

Test Plan:
- Read to slave acking 1 cycle after strobe, rdata=32'h1234_5678 -> bus_s.ren one pulse at N+1; bus_m.ack at N+3 with rdata=32'h1234_5678, err=0.
- Write to addr 32'h0030_0010, slave never acks, TMO=255 -> bus_m.ack exactly 256 cycles after the bus_s.wen cycle; err=1, rdata=32'hDEAD_C0DE, tmo_cnt_o=1.
- Slave ack exactly on the TMO-th cycle -> normal response, err=0, tmo_cnt_o unchanged. Slave ack 2 cycles after timeout -> discarded, no extra bus_m.ack.
- Second read strobe 3 cycles into WAIT -> no second bus_s.ren, ovr_o=1. clr_i -> ovr_o=0 next cycle.
- TW=4, 20 consecutive timeouts -> tmo_cnt_o saturates at 15.
- rst_i pulsed mid-WAIT, then slave ack -> all outputs 0, no bus_m.ack. Next read completes normally.
